// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state encoding and baud divider helper for the UART receiver
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
        return int'((clk_freq + (baud * os) / 2) / (baud * os));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; head is visible combinationally while non-empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           sysclk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           valid,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_pop;
    logic             do_push;

    assign valid   = cnt_q != '0;
    assign full    = cnt_q == FULL_CNT;
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt_q;
    assign rdata   = valid ? mem_q[rd_q] : '0;

    // storage write; contents need no reset since reads are gated by valid
    always_ff @(posedge sysclk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled, majority-voted UART receiver with configurable framing and receive FIFO
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              sysclk,
    input  logic                              reset,
    input  logic                              rxd,
    input  logic                              rd_en,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic [1:0]           sync_q;
    logic                 line_q;
    state_e               state_q;
    logic [DW-1:0]        div_q, div_d;
    logic [OW-1:0]        os_q, os_d;
    logic [1:0]           smp_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_err_q;
    logic                 stop_bad_q;
    logic                 frame_err_q, parity_err_q, overrun_q;
    logic                 rx_s, tick, mid, vote, stop_bad, push, full;

    assign rx_s     = sync_q[1];
    assign tick     = state_q != S_IDLE && div_q == DW'(DIV - 1);
    assign mid      = tick && os_q == OW'(OVERSAMPLE / 2);
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign stop_bad = stop_bad_q | ~vote;
    assign push     = mid && state_q == S_STOP && bit_q == LAST_STOP && !stop_bad && !par_err_q && (!full || rd_en);

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    // tick generator is held at zero while idle so each frame starts from a clean phase
    always_comb begin
        div_d = (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;
        os_d  = state_q == S_IDLE ? '0 : tick ? (os_q == OW'(OVERSAMPLE - 1) ? '0 : os_q + 1'b1) : os_q;
    end

    // synchroniser, edge history, tick counters and the two early vote samples
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            line_q <= 1'b1;
            div_q  <= '0;
            os_q   <= '0;
            smp_q  <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
            line_q <= rx_s;
            div_q  <= div_d;
            os_q   <= os_d;
            smp_q[0] <= (tick && os_q == OW'(OVERSAMPLE / 2 - 2)) ? rx_s : smp_q[0];
            smp_q[1] <= (tick && os_q == OW'(OVERSAMPLE / 2 - 1)) ? rx_s : smp_q[1];
        end
    end

    // frame FSM; decisions are taken at the voted mid-point of each bit
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_q        <= '0;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            case (state_q)
                S_IDLE: if (line_q && !rx_s) state_q <= S_START;
                S_START: if (mid) begin
                    state_q    <= vote ? S_IDLE : S_DATA;
                    bit_q      <= '0;
                    par_err_q  <= 1'b0;
                    stop_bad_q <= 1'b0;
                end
                S_DATA: if (mid) begin
                    data_q  <= {vote, data_q[DATA_BITS-1:1]};
                    bit_q   <= bit_q == LAST_DATA ? '0 : bit_q + 1'b1;
                    state_q <= bit_q != LAST_DATA ? S_DATA : PARITY != PAR_NONE ? S_PARITY : S_STOP;
                end
                S_PARITY: if (mid) begin
                    par_err_q <= (^data_q ^ vote) != (PARITY == PAR_ODD);
                    state_q   <= S_STOP;
                end
                S_STOP: if (mid) begin
                    stop_bad_q <= stop_bad;
                    bit_q      <= bit_q + 1'b1;
                    if (bit_q == LAST_STOP) begin
                        state_q      <= (stop_bad && data_q == '0) ? S_BREAK : S_IDLE;
                        frame_err_q  <= stop_bad;
                        parity_err_q <= !stop_bad && par_err_q;
                        overrun_q    <= !stop_bad && !par_err_q && full && !rd_en;
                    end
                end
                S_BREAK: if (rx_s) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (push),
        .wdata  (data_q),
        .pop    (rd_en),
        .rdata  (rd_data),
        .valid  (rd_valid),
        .full   (full),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames against a queue-based receiver model
module tb_uart_rx_param;
    localparam int CLK_A = 3_700_000, BAUD_A = 100_000, OS_A = 8;
    localparam int CLK_B = 3_200_000, BAUD_B = 50_000,  OS_B = 16;
    localparam int BT_A  = OS_A * ((CLK_A + BAUD_A * OS_A / 2) / (BAUD_A * OS_A));
    localparam int BT_B  = OS_B * ((CLK_B + BAUD_B * OS_B / 2) / (BAUD_B * OS_B));
    localparam int DEPTH = 4;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd [2];
    logic       rd_en [2];
    logic [7:0] rd_data [2];
    logic       rd_valid [2];
    logic [2:0] cnt [2];
    logic       fe [2], pe [2], ov [2];
    int         fe_cnt [2], pe_cnt [2], ov_cnt [2];
    int         exp_fe [2], exp_pe [2], exp_ov [2];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int         n_cmp = 0, n_err = 0, dec_lat = -1, last_lat = -1;

    always #5 sysclk = ~sysclk;

    uart_rx_param #(.CLK_FREQ(CLK_A), .BAUD(BAUD_A), .OVERSAMPLE(OS_A), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .sysclk(sysclk), .reset(reset), .rxd(rxd[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .fifo_count(cnt[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

    uart_rx_param #(.CLK_FREQ(CLK_B), .BAUD(BAUD_B), .OVERSAMPLE(OS_B), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .sysclk(sysclk), .reset(reset), .rxd(rxd[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .fifo_count(cnt[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

    always @(posedge sysclk) begin
        for (int k = 0; k < 2; k++) begin
            if (fe[k]) fe_cnt[k] <= fe_cnt[k] + 1;
            if (pe[k]) pe_cnt[k] <= pe_cnt[k] + 1;
            if (ov[k]) ov_cnt[k] <= ov_cnt[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int qsize(input int k);
        return k == 0 ? qa.size() : qb.size();
    endfunction

    function automatic logic [7:0] qhead(input int k);
        return k == 0 ? qa[0] : qb[0];
    endfunction

    task automatic qpush(input int k, input logic [7:0] d);
        if (k == 0) qa.push_back(d); else qb.push_back(d);
    endtask

    task automatic qpop(input int k);
        if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    endtask

    task automatic chk_state(input int k, input string tag);
        chk({tag, " frame_err count"}, fe_cnt[k], exp_fe[k]);
        chk({tag, " parity_err count"}, pe_cnt[k], exp_pe[k]);
        chk({tag, " overrun count"}, ov_cnt[k], exp_ov[k]);
        chk({tag, " fifo_count"}, cnt[k], qsize(k));
        chk({tag, " rd_valid"}, rd_valid[k], qsize(k) != 0);
        if (qsize(k) > 0) chk({tag, " rd_data"}, rd_data[k], qhead(k));
    endtask

    task automatic pop1(input int k);
        rd_en[k] = 1'b1;
        @(negedge sysclk);
        rd_en[k] = 1'b0;
        if (qsize(k) > 0) qpop(k);
    endtask

    task automatic drain(input int k, input string tag);
        while (qsize(k) > 0) begin
            chk({tag, " drain rd_valid"}, rd_valid[k], 1);
            chk({tag, " drain rd_data"}, rd_data[k], qhead(k));
            pop1(k);
        end
        chk({tag, " drained fifo_count"}, cnt[k], 0);
        chk({tag, " drained rd_valid"}, rd_valid[k], 0);
    endtask

    // k=0: 8N1 receiver; k=1: 8E2 receiver. pop_at pulses rd_en at that cycle of the last stop bit.
    task automatic send_frame(input int k, input logic [7:0] d, input bit par_flip, input bit s0,
                              input bit s1, input int gap, input int pop_at);
        bit         seq [$];
        int         bt, l;
        logic [2:0] c0;
        bit         full_np, stop_ok;
        bt = k == 0 ? BT_A : BT_B;
        rxd[k] = 1'b1;
        repeat (gap * bt) @(negedge sysclk);
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(d[i]);
        if (k == 1) seq.push_back(^d ^ par_flip);
        seq.push_back(s0);
        if (k == 1) seq.push_back(s1);
        for (int j = 0; j < seq.size() - 1; j++) begin
            rxd[k] = seq[j];
            repeat (bt) @(negedge sysclk);
        end
        rxd[k] = seq[seq.size() - 1];
        c0 = cnt[k];
        l = -1;
        for (int i = 0; i < bt; i++) begin
            rd_en[k] = (i == pop_at);
            @(negedge sysclk);
            if (l < 0 && cnt[k] != c0) l = i;
        end
        rd_en[k] = 1'b0;
        last_lat = l;
        full_np = qsize(k) == DEPTH && pop_at < 0;
        if (pop_at >= 0 && qsize(k) > 0) qpop(k);
        stop_ok = k == 0 ? s0 : (s0 & s1);
        if (!stop_ok) exp_fe[k]++;
        else if (k == 1 && par_flip) exp_pe[k]++;
        else if (full_np) exp_ov[k]++;
        else qpush(k, d);
        chk_state(k, $sformatf("rx%0d byte %02h", k, d));
    endtask

    initial begin
        rxd[0] = 1'b1; rxd[1] = 1'b1;
        rd_en[0] = 1'b0; rd_en[1] = 1'b0;
        repeat (3) @(negedge sysclk);
        for (int k = 0; k < 2; k++) begin
            chk("reset rd_valid", rd_valid[k], 0);
            chk("reset fifo_count", cnt[k], 0);
            chk("reset rd_data", rd_data[k], 0);
            chk("reset pulses", {fe[k], pe[k], ov[k]}, 0);
        end
        reset = 1'b1;
        repeat (2) @(negedge sysclk);

        send_frame(0, 8'hB9, 0, 1, 1, 1, -1);
        drain(0, "single");

        send_frame(0, 8'h96, 0, 1, 1, 1, -1);
        send_frame(0, 8'h1E, 0, 1, 1, 0, -1);
        drain(0, "back2back");

        send_frame(1, 8'h96, 1, 1, 1, 1, -1);
        send_frame(1, 8'h1E, 0, 1, 1, 1, -1);
        drain(1, "parity");

        send_frame(0, 8'h55, 0, 0, 1, 1, -1);
        rxd[0] = 1'b1;
        repeat (BT_A) @(negedge sysclk);
        rxd[0] = 1'b0;
        repeat (20 * BT_A) @(negedge sysclk);
        exp_fe[0]++;
        chk_state(0, "break held");
        send_frame(0, 8'hA5, 0, 1, 1, 1, -1);
        drain(0, "after break");

        for (int d = 1; d <= 5; d++) begin
            send_frame(0, 8'(d), 0, 1, 1, 1, -1);
            if (d == 4) dec_lat = last_lat;
        end
        chk("push latency found", dec_lat >= 0, 1);
        drain(0, "overrun");
        for (int d = 1; d <= 4; d++) send_frame(0, 8'(d), 0, 1, 1, 1, -1);
        send_frame(0, 8'h05, 0, 1, 1, 1, dec_lat);
        drain(0, "push+pop full");

        rxd[0] = 1'b0;
        repeat (BT_A / 5) @(negedge sysclk);
        rxd[0] = 1'b1;
        repeat (2 * BT_A) @(negedge sysclk);
        chk_state(0, "glitch");

        rxd[0] = 1'b0;
        repeat (BT_A) @(negedge sysclk);
        for (int i = 0; i < 3; i++) begin
            rxd[0] = i != 2;
            repeat (BT_A) @(negedge sysclk);
        end
        reset = 1'b0;
        rxd[0] = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("midreset rd_valid", rd_valid[0], 0);
        chk("midreset fifo_count", cnt[0], 0);
        chk("midreset rd_data", rd_data[0], 0);
        chk("midreset pulses", {fe[0], pe[0], ov[0]}, 0);
        reset = 1'b1;
        repeat (2 * BT_A) @(negedge sysclk);
        send_frame(0, 8'h3C, 0, 1, 1, 1, -1);
        drain(0, "after reset");

        for (int r = 0; r < 16; r++) begin
            int         k;
            logic [7:0] d;
            bit         pf, s0, s1;
            k  = r % 2;
            d  = 8'($urandom);
            s0 = $urandom_range(0, 4) != 0;
            s1 = $urandom_range(0, 4) != 0;
            pf = k == 1 && $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 2) == 0 && qsize(k) > 0) pop1(k);
            send_frame(k, d, pf, s0, s1, 1, -1);
        end
        drain(0, "random A");
        drain(1, "random B");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
